// File: rtl/max_pool_1_ctrl.sv
// max_pool_1_ctrl
//   Sequencer for the first 2x2/stride-2 max-pool layer. On start it walks
//   every 2x2 window of a channel-major IN_W x IN_H x CHANNELS feature map,
//   reads the four samples from the source BRAM, folds them into a signed
//   maximum and writes one pooled word per window to the destination BRAM.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   start               begin a run (only honoured in IDLE)
//   src_base, dst_base  byte base addresses, latched at start, word aligned
//   busy, done          run in progress / one-cycle completion pulse
//   src_addr, src_en    source BRAM read port (data returns next cycle)
//   src_dout            source BRAM read data
//   dst_addr, dst_din   destination BRAM write address / data
//   dst_en, dst_we      destination enable / byte write enables
module max_pool_1_ctrl #(
   parameter int IN_W     = 32,
   parameter int IN_H     = 32,
   parameter int CHANNELS = 32
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [31:0] src_base,
   input  logic [31:0] dst_base,
   output logic        busy,
   output logic        done,
   output logic [31:0] src_addr,
   output logic        src_en,
   input  logic [31:0] src_dout,
   output logic [31:0] dst_addr,
   output logic [31:0] dst_din,
   output logic        dst_en,
   output logic [3:0]  dst_we
);

   localparam int OUT_W = IN_W / 2;
   localparam int OUT_H = IN_H / 2;
   localparam int XW    = (OUT_W > 1) ? $clog2(OUT_W) : 1;
   localparam int YW    = (OUT_H > 1) ? $clog2(OUT_H) : 1;
   localparam int CW    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

   localparam logic [XW-1:0] X_LAST = XW'(OUT_W - 1);
   localparam logic [YW-1:0] Y_LAST = YW'(OUT_H - 1);
   localparam logic [CW-1:0] C_LAST = CW'(CHANNELS - 1);

   // Byte distance from the top-left sample to the one directly below it.
   localparam logic [31:0] ROW_B  = 32'(4 * IN_W);
   // Top-left pointer step when x' wraps: the last window of a row pair sits
   // two columns before the row end, so +8 lands on the odd row and a further
   // row skip reaches the next even row (or the next channel's row 0).
   localparam logic [31:0] WRAP_B = 32'(4 * IN_W + 8);

   if (IN_W < 2 || (IN_W % 2) != 0 || IN_H < 2 || (IN_H % 2) != 0 || CHANNELS < 1)
   begin : g_param_err
      $error("max_pool_1_ctrl: IN_W/IN_H must be even and >= 2, CHANNELS >= 1");
   end

   typedef enum logic [2:0] {
      S_IDLE,
      S_READ,
      S_DRAIN,
      S_WRITE,
      S_DONE
   } state_t;

   state_t          state, state_nx;
   logic [1:0]      k;
   logic [XW-1:0]   xc;
   logic [YW-1:0]   yc;
   logic [CW-1:0]   cc;
   logic            last_win;
   logic [31:0]     win_ptr;
   logic [31:0]     dst_ptr;
   logic [31:0]     rd_addr;
   logic [31:0]     acc;
   logic            smp_vld;
   logic            smp_first;
   logic [31:0]     src_addr_q;
   logic [31:0]     dst_addr_q;
   logic [31:0]     dst_din_q;

   assign last_win = (xc == X_LAST) && (yc == Y_LAST) && (cc == C_LAST);

   // ------------------------------------------------------------------ FSM
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:  if (start) state_nx = S_READ;
         S_READ:  if (k == 2'd3) state_nx = S_DRAIN;
         S_DRAIN: state_nx = S_WRITE;
         S_WRITE: state_nx = last_win ? S_DONE : S_READ;
         S_DONE:  state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   // Sample k of the current window: (0,0) (0,1) (1,0) (1,1) relative to top-left.
   always_comb begin
      rd_addr = win_ptr;
      case (k)
         2'd0: rd_addr = win_ptr;
         2'd1: rd_addr = win_ptr + 32'd4;
         2'd2: rd_addr = win_ptr + ROW_B;
         2'd3: rd_addr = win_ptr + ROW_B + 32'd4;
         default: rd_addr = win_ptr;
      endcase
   end

   // ------------------------------------------- window counters / pointers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         k       <= '0;
         xc      <= '0;
         yc      <= '0;
         cc      <= '0;
         win_ptr <= '0;
         dst_ptr <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  win_ptr <= src_base & 32'hFFFF_FFFC;
                  dst_ptr <= dst_base & 32'hFFFF_FFFC;
                  k       <= '0;
                  xc      <= '0;
                  yc      <= '0;
                  cc      <= '0;
               end
            end
            S_READ: k <= k + 2'd1;
            S_WRITE: begin
               dst_ptr <= dst_ptr + 32'd4;
               if (xc == X_LAST) begin
                  xc      <= '0;
                  win_ptr <= win_ptr + WRAP_B;
                  if (yc == Y_LAST) begin
                     yc <= '0;
                     cc <= (cc == C_LAST) ? '0 : cc + 1'b1;
                  end else begin
                     yc <= yc + 1'b1;
                  end
               end else begin
                  xc      <= xc + 1'b1;
                  win_ptr <= win_ptr + 32'd8;
               end
            end
            default: ;
         endcase
      end
   end

   // ------------------------------------------------------ max accumulator
   // Read data trails src_en by one cycle, so the sample-valid flags are a
   // one-cycle delayed copy of the read issue.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         smp_vld   <= 1'b0;
         smp_first <= 1'b0;
         acc       <= '0;
      end else begin
         smp_vld   <= (state == S_READ);
         smp_first <= (state == S_READ) && (k == 2'd0);
         if (smp_vld && (smp_first || ($signed(src_dout) > $signed(acc))))
            acc <= src_dout;
      end
   end

   // ----------------------------------------------- output hold registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         src_addr_q <= '0;
         dst_addr_q <= '0;
         dst_din_q  <= '0;
      end else begin
         if (state == S_READ) src_addr_q <= rd_addr;
         if (state == S_WRITE) begin
            dst_addr_q <= dst_ptr;
            dst_din_q  <= acc;
         end
      end
   end

   // Outputs decode from the state register so reset clears them at once.
   assign src_en   = (state == S_READ);
   assign src_addr = src_en ? rd_addr : src_addr_q;
   assign dst_en   = (state == S_WRITE);
   assign dst_we   = {4{dst_en}};
   assign dst_addr = dst_en ? dst_ptr : dst_addr_q;
   assign dst_din  = dst_en ? acc : dst_din_q;
   assign busy     = (state == S_READ) || (state == S_DRAIN) || (state == S_WRITE);
   assign done     = (state == S_DONE);

endmodule

// File: tb/tb_max_pool_1_ctrl.sv
// Scoreboard bench for max_pool_1_ctrl on a 4x4x2 map. The stimulus side
// computes every expected read and write (address, data, cycle offset from
// start) and queues them; a monitor on the falling edge pops and compares.
module tb_max_pool_1_ctrl;

   localparam int W    = 4;
   localparam int H    = 4;
   localparam int C    = 2;
   localparam int NW   = W * H * C;
   localparam int N    = C * (H / 2) * (W / 2);
   localparam int LAST = 6 * N;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [31:0] src_base = '0;
   logic [31:0] dst_base = '0;
   logic        busy, done, src_en, dst_en;
   logic [31:0] src_addr, dst_addr, dst_din;
   logic [31:0] src_dout = '0;
   logic [3:0]  dst_we;

   max_pool_1_ctrl #(.IN_W(W), .IN_H(H), .CHANNELS(C)) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .src_base(src_base), .dst_base(dst_base),
      .busy(busy), .done(done),
      .src_addr(src_addr), .src_en(src_en), .src_dout(src_dout),
      .dst_addr(dst_addr), .dst_din(dst_din), .dst_en(dst_en), .dst_we(dst_we)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      int          off;
   } xact_t;

   xact_t       rd_q[$];
   xact_t       wr_q[$];
   logic [31:0] mem [0:NW-1];
   logic [31:0] sb_al = '0;
   int          cs = 0;
   bit          active = 1'b0;
   int          total = 0;
   int          bad = 0;

   // Source BRAM: one-cycle read latency.
   always @(posedge clk)
      if (src_en) src_dout <= mem[5'((src_addr - sb_al) >> 2)];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%h want=%h (cycle offset %0d)", nm, act, exp, cyc - cs);
      end
   endtask

   // Reference: walk windows in x', r', c order and take the signed max.
   task automatic build(input logic [31:0] sb, input logic [31:0] db);
      int o, wi;
      logic signed [31:0] m;
      logic [31:0] db_al;
      sb_al = sb & 32'hFFFF_FFFC;
      db_al = db & 32'hFFFF_FFFC;
      o = 1;
      wi = 0;
      for (int c = 0; c < C; c++)
         for (int y = 0; y < H / 2; y++)
            for (int x = 0; x < W / 2; x++) begin
               m = '0;
               for (int k = 0; k < 4; k++) begin
                  int e;
                  e = c * H * W + (2 * y + k / 2) * W + 2 * x + k % 2;
                  rd_q.push_back('{sb_al + 32'(4 * e), 32'h0, o + k});
                  if (k == 0 || $signed(mem[e]) > m) m = mem[e];
               end
               wr_q.push_back('{db_al + 32'(4 * wi), m, o + 5});
               wi++;
               o += 6;
            end
   endtask

   // Monitor: checks every falling edge, plus an immediate check when reset
   // drops during the high clock phase.
   logic [31:0] last_sa = '0, last_da = '0, last_dd = '0;
   always begin
      @(negedge clk or negedge rst_n);
      if (clk) begin
         #1;
         chk("rst_busy", busy, 0);
         chk("rst_done", done, 0);
         chk("rst_src_en", src_en, 0);
         chk("rst_dst_en", dst_en, 0);
         chk("rst_dst_we", dst_we, 0);
         chk("rst_src_addr", src_addr, 0);
         chk("rst_dst_addr", dst_addr, 0);
         chk("rst_dst_din", dst_din, 0);
         rd_q.delete();
         wr_q.delete();
         last_sa = '0; last_da = '0; last_dd = '0;
      end else begin
         int o;
         xact_t it;
         if (!rst_n) begin
            last_sa = '0; last_da = '0; last_dd = '0;
         end
         o = cyc - cs;
         chk("busy", busy, active && o >= 1 && o <= LAST);
         chk("done", done, active && o == LAST + 1);
         if (src_en) begin
            chk("rd_expected", rd_q.size() > 0, 1);
            if (rd_q.size() > 0) begin
               it = rd_q.pop_front();
               chk("rd_addr", src_addr, it.addr);
               chk("rd_cycle", o, it.off);
            end
            last_sa = src_addr;
         end else begin
            chk("src_addr_hold", src_addr, last_sa);
         end
         if (dst_en) begin
            chk("wr_expected", wr_q.size() > 0, 1);
            chk("wr_we", dst_we, 4'hF);
            if (wr_q.size() > 0) begin
               it = wr_q.pop_front();
               chk("wr_addr", dst_addr, it.addr);
               chk("wr_data", dst_din, it.data);
               chk("wr_cycle", o, it.off);
            end
            last_da = dst_addr;
            last_dd = dst_din;
         end else begin
            chk("wr_we_idle", dst_we, 0);
            chk("dst_addr_hold", dst_addr, last_da);
            chk("dst_din_hold", dst_din, last_dd);
         end
         if (active && o == LAST + 3) begin
            chk("rd_left", rd_q.size(), 0);
            chk("wr_left", wr_q.size(), 0);
         end
      end
   end

   // One run: start for one cycle, optional extra start pulses and an
   // optional mid-run reset at the given cycle offsets (0 = none).
   task automatic run(input logic [31:0] sb, input logic [31:0] db,
                      input int p1, input int p2, input int rst_at);
      @(posedge clk); #1;
      build(sb, db);
      src_base = sb;
      dst_base = db;
      start    = 1'b1;
      cs       = cyc;
      active   = 1'b1;
      for (int o = 1; o <= LAST + 4; o++) begin
         @(posedge clk); #1;
         start = (o == p1 || o == p2);
         if (o == rst_at) begin
            #2;
            active = 1'b0;
            rst_n  = 1'b0;
            @(posedge clk); #1;
            @(posedge clk); #1;
            rst_n = 1'b1;
            return;
         end
      end
      start  = 1'b0;
      active = 1'b0;
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (2) @(posedge clk);

      // word i = i: pooled values 5,7,13,15,21,23,29,31 at 0x00..0x1C
      for (int i = 0; i < NW; i++) mem[i] = 32'(i);
      run(32'h0, 32'h0, 0, 0, 0);

      // small signed values with ties; unaligned bases; stray start pulses
      for (int i = 0; i < NW; i++) mem[i] = 32'($urandom_range(0, 8)) - 32'd4;
      run(32'h1003, 32'h2002, 10, 48, 0);

      // full-range random data, reset mid-run, then a clean rerun
      for (int i = 0; i < NW; i++) mem[i] = $urandom;
      run(32'h0, 32'h0, 0, 0, 20);
      repeat (3) @(posedge clk);
      run(32'h0, 32'h0, 0, 0, 0);

      // random bases and data
      for (int t = 0; t < 3; t++) begin
         for (int i = 0; i < NW; i++)
            mem[i] = (t == 1) ? (32'h8000_0000 | 32'($urandom_range(0, 3))) : $urandom;
         run($urandom, $urandom, 0, 0, 0);
      end

      repeat (5) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
